cnn_layer_accel_weight_sequencer: RTL and testbench
===================================================

Name: cnn_layer_accel_weight_sequencer

Overview:
- Control FSM that drives the QUAD weight sequence table lookup.
- For each output pixel it generates the gray_code, sequence_selector and seq_data_addr stream.
- Iterates over a programmed grid of output rows and columns, with start/busy/done handshake and stall support.
- Emits a valid strobe aligned to the table's 1-cycle registered wht_data_addr output.

Parameters:
- C_ROW_CNT_W, 10, width of the num_rows input and the row counter.
- C_COL_CNT_W, 10, width of the num_cols input and the column counter.
- C_SEQ_LEN, 5, sequence entries per pixel; legal range 1..8; seq_data_addr runs 0..C_SEQ_LEN-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle pulse; begins a job; accepted only in IDLE.
- num_rows  in  C_ROW_CNT_W  output rows in the job; sampled on an accepted start.
- num_cols  in  C_COL_CNT_W  output pixels per row; sampled on an accepted start.
- stall  in  1  downstream backpressure; freezes the sequencer.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  1-cycle pulse at job end.
- gray_code  out  2  row-phase code to the table.
- sequence_selector  out  1  column-parity select to the table.
- seq_data_addr  out  3  sequence index to the table.
- seq_valid  out  1  current table inputs are a real request.
- last_seq  out  1  qualifies the final seq_valid entry of the job.
- wht_data_valid  out  1  seq_valid delayed 1 cycle; aligned with table wht_data_addr.
- dbg_issue_cnt  out  32  issued-entry count (see Optional Feature).

Behaviour:
- Reset values: state=IDLE; busy, done, seq_valid, last_seq, wht_data_valid = 0; gray_code=2'b00; sequence_selector=1; seq_data_addr=0; all counters=0.
- Reset asserted mid-job aborts immediately to these values, with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start when num_rows!=0 and num_cols!=0; latch both inputs.
- IDLE -> DONE on start when either is 0; no seq_valid is issued for that job.
- start in RUN or DONE is ignored.
- RUN, per cycle with stall=0:
  - seq_valid=1.
  - seq_data_addr increments 0..C_SEQ_LEN-1.
  - At C_SEQ_LEN-1: seq_data_addr wraps to 0, sequence_selector toggles, col_cnt++.
  - At the last column: col_cnt wraps to 0, sequence_selector reloads 1, row_cnt++, gray_code advances 00->01->11->10->00 (wraps every 4 rows).
- First entry of each row: sequence_selector=1. First row of each job: gray_code=00.
- last_seq=1 with the entry where row=num_rows-1, col=num_cols-1, addr=C_SEQ_LEN-1; next state is DONE.
- RUN with stall=1: seq_valid=0; counters, gray_code, sequence_selector and seq_data_addr hold.
- A stall arriving on the last_seq entry suppresses that entry; it reissues when stall drops.
- stall is ignored in IDLE and DONE.
- DONE: done=1 and busy=1 for exactly 1 cycle, then IDLE with busy=0.
  - DONE coincides with the wht_data_valid of the last entry.
  - gray_code and sequence_selector return to their reset values on entry to IDLE.
- wht_data_valid is a register of (seq_valid & ~rst).
- Total seq_valid count per job = num_rows * num_cols * C_SEQ_LEN.
- Job latency, start to done, with no stall = num_rows*num_cols*C_SEQ_LEN + 1 cycles.

Optional Feature:
- Macro: CNN_LAYER_ACCEL_WHT_SEQ_DBG_CNT_EN.
- Defined: dbg_issue_cnt is a 32-bit counter.
  - Clears on rst and on an accepted start.
  - Increments on every seq_valid cycle.
  - Saturates at 32'hFFFFFFFF.
  - Holds its value after done.
- Undefined: dbg_issue_cnt is tied to 0 and no counter logic is synthesized.

Test Plan:
- Basic job, num_rows=1, num_cols=2, C_SEQ_LEN=5, no stall -> seq_data_addr 0,1,2,3,4,0,1,2,3,4; sequence_selector 1x5 then 0x5; gray_code=00 throughout; last_seq on the 10th entry; done 11 cycles after start.
- Gray wrap, num_rows=5, num_cols=1 -> gray_code per row 00,01,11,10,00; sequence_selector=1 at every row start; 25 seq_valid total.
- Stall, 3-cycle stall at entry 3 of num_rows=1, num_cols=1 -> seq_data_addr holds at 3 with seq_valid=0 for 3 cycles; sequence resumes 3,4; done is 3 cycles later than the unstalled job.
- Zero size, start with num_cols=0 -> DONE next cycle, done pulse, zero seq_valid; start during busy has no effect.
- Reset mid-job, rst at row 1, col 0, addr 2 -> next cycle all outputs at reset values, no done pulse; a new start runs a full job correctly.
- Debug counter with macro defined, num_rows=2, num_cols=3 -> dbg_issue_cnt=30 at done; clears on the next start.
- Debug counter with macro undefined -> dbg_issue_cnt=0 throughout.

Source files
------------

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_weight_sequencer
//
// Control FSM that walks a programmed grid of output rows x columns and, for
// each output pixel, issues C_SEQ_LEN lookups into the QUAD weight sequence
// table (gray_code / sequence_selector / seq_data_addr). A valid strobe is
// delayed by one cycle to line up with the table's registered wht_data_addr.
//
// Optional feature: define CNN_LAYER_ACCEL_WHT_SEQ_DBG_CNT_EN to build a
// saturating 32-bit count of issued entries on dbg_issue_cnt; otherwise
// dbg_issue_cnt is tied to zero.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               1-cycle job start pulse (accepted only in IDLE)
//   num_rows, num_cols  job grid size, sampled on an accepted start
//   stall               downstream backpressure, freezes the sequencer
//   busy, done          job handshake
//   gray_code           row-phase code (00,01,11,10 repeating)
//   sequence_selector   column-parity select (1 on the first pixel of a row)
//   seq_data_addr       sequence index 0..C_SEQ_LEN-1
//   seq_valid, last_seq current table request / final request of the job
//   wht_data_valid      seq_valid delayed one cycle
//   dbg_issue_cnt       issued-entry count (debug build only)
// ---------------------------------------------------------------------------
module cnn_layer_accel_weight_sequencer #(
    parameter int C_ROW_CNT_W = 10,
    parameter int C_COL_CNT_W = 10,
    parameter int C_SEQ_LEN   = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [C_ROW_CNT_W-1:0] num_rows,
    input  logic [C_COL_CNT_W-1:0] num_cols,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             gray_code,
    output logic                   sequence_selector,
    output logic [2:0]             seq_data_addr,
    output logic                   seq_valid,
    output logic                   last_seq,
    output logic                   wht_data_valid,
    output logic [31:0]            dbg_issue_cnt
);

    localparam logic [2:0] LAST_ADDR = 3'(C_SEQ_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [C_ROW_CNT_W-1:0] numRows_q, numRows_d;
    logic [C_COL_CNT_W-1:0] numCols_q, numCols_d;
    logic [C_ROW_CNT_W-1:0] rowCnt_q, rowCnt_d;
    logic [C_COL_CNT_W-1:0] colCnt_q, colCnt_d;
    logic [2:0]             addr_q, addr_d;
    logic [1:0]             gray_q, gray_d;
    logic                   sel_q, sel_d;
    logic                   whtValid_q, whtValid_d;
    logic                   lastCol;
    logic                   lastEntry;
    logic                   issue;

    // Row-phase code follows a 2-bit reflected Gray sequence.
    function automatic logic [1:0] grayNext(input logic [1:0] g);
        logic [1:0] n;
        case (g)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            numRows_q  <= '0;
            numCols_q  <= '0;
            rowCnt_q   <= '0;
            colCnt_q   <= '0;
            addr_q     <= '0;
            gray_q     <= 2'b00;
            sel_q      <= 1'b1;
            whtValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            numRows_q  <= numRows_d;
            numCols_q  <= numCols_d;
            rowCnt_q   <= rowCnt_d;
            colCnt_q   <= colCnt_d;
            addr_q     <= addr_d;
            gray_q     <= gray_d;
            sel_q      <= sel_d;
            whtValid_q <= whtValid_d;
        end
    end

    // Next-state and output logic. The last entry clears the walk state
    // directly, so gray_code/sequence_selector are already at their idle
    // values during DONE.
    always_comb begin
        state_d   = state_q;
        numRows_d = numRows_q;
        numCols_d = numCols_q;
        rowCnt_d  = rowCnt_q;
        colCnt_d  = colCnt_q;
        addr_d    = addr_q;
        gray_d    = gray_q;
        sel_d     = sel_q;

        issue     = (state_q == ST_RUN) && !stall;
        lastCol   = (colCnt_q == numCols_q - C_COL_CNT_W'(1));
        lastEntry = (rowCnt_q == numRows_q - C_ROW_CNT_W'(1)) && lastCol &&
                    (addr_q == LAST_ADDR);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    numRows_d = num_rows;
                    numCols_d = num_cols;
                    // An empty grid still completes the handshake.
                    if ((num_rows != '0) && (num_cols != '0)) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (lastEntry) begin
                        state_d  = ST_DONE;
                        rowCnt_d = '0;
                        colCnt_d = '0;
                        addr_d   = '0;
                        gray_d   = 2'b00;
                        sel_d    = 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        if (lastCol) begin
                            colCnt_d = '0;
                            sel_d    = 1'b1;
                            rowCnt_d = rowCnt_q + C_ROW_CNT_W'(1);
                            gray_d   = grayNext(gray_q);
                        end else begin
                            colCnt_d = colCnt_q + C_COL_CNT_W'(1);
                            sel_d    = ~sel_q;
                        end
                    end else begin
                        addr_d = addr_q + 3'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gray_d  = 2'b00;
                sel_d   = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        whtValid_d        = issue && !rst;

        busy              = (state_q != ST_IDLE);
        done              = (state_q == ST_DONE);
        seq_valid         = issue;
        last_seq          = issue && lastEntry;
        gray_code         = gray_q;
        sequence_selector = sel_q;
        seq_data_addr     = addr_q;
        wht_data_valid    = whtValid_q;
    end

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_DBG_CNT_EN
    logic [31:0] dbgCnt_q;

    // Saturating issue counter, restarted by every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbgCnt_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            dbgCnt_q <= '0;
        end else if (issue && (dbgCnt_q != 32'hFFFF_FFFF)) begin
            dbgCnt_q <= dbgCnt_q + 32'd1;
        end
    end

    assign dbg_issue_cnt = dbgCnt_q;
`else
    assign dbg_issue_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_accel_weight_sequencer
//
// Directed plus randomized jobs against a queue-based reference model: each
// job's expected request stream is generated from the row/column/index loop
// nest, and the bench walks it cycle by cycle while applying stall.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_weight_sequencer;

    localparam int ROW_W   = 10;
    localparam int COL_W   = 10;
    localparam int SEQ_LEN = 5;

`ifdef CNN_LAYER_ACCEL_WHT_SEQ_DBG_CNT_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ROW_W-1:0] numRows;
    logic [COL_W-1:0] numCols;
    logic             stall;
    logic             busy;
    logic             done;
    logic [1:0]       grayCode;
    logic             seqSel;
    logic [2:0]       seqAddr;
    logic             seqValid;
    logic             lastSeq;
    logic             whtValid;
    logic [31:0]      dbgCnt;

    int testsRun  = 0;
    int failCount = 0;

    typedef struct {
        logic [1:0] gray;
        logic       sel;
        logic [2:0] addr;
        logic       last;
    } entry_t;

    entry_t expQ[$];

    cnn_layer_accel_weight_sequencer #(
        .C_ROW_CNT_W (ROW_W),
        .C_COL_CNT_W (COL_W),
        .C_SEQ_LEN   (SEQ_LEN)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .num_rows          (numRows),
        .num_cols          (numCols),
        .stall             (stall),
        .busy              (busy),
        .done              (done),
        .gray_code         (grayCode),
        .sequence_selector (seqSel),
        .seq_data_addr     (seqAddr),
        .seq_valid         (seqValid),
        .last_seq          (lastSeq),
        .wht_data_valid    (whtValid),
        .dbg_issue_cnt     (dbgCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Row r of a job uses the r-th code of the 2-bit reflected Gray cycle.
    function automatic logic [1:0] rowGray(input int r);
        logic [1:0] tbl [4];
        tbl = '{2'b00, 2'b01, 2'b11, 2'b10};
        return tbl[r % 4];
    endfunction

    task automatic buildExpected(input int rows, input int cols);
        entry_t e;
        expQ.delete();
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                for (int a = 0; a < SEQ_LEN; a++) begin
                    e.gray = rowGray(r);
                    e.sel  = ((c % 2) == 0);
                    e.addr = 3'(a);
                    e.last = (r == rows - 1) && (c == cols - 1) && (a == SEQ_LEN - 1);
                    expQ.push_back(e);
                end
            end
        end
    endtask

    // Start pulse issued in IDLE; stall is randomized since IDLE ignores it.
    task automatic applyStimulus(input int rows, input int cols);
        @(negedge clk);
        start   = 1'b1;
        numRows = ROW_W'(rows);
        numCols = COL_W'(cols);
        stall   = 1'($urandom_range(0, 1));
        #1;
        checkOutput("idleBusy", 32'(busy), 32'd0);
    endtask

    // Runs one job. pct>0 selects random stall; otherwise stallAt>=0 stalls
    // stallLen cycles at that entry. pokeCycle pulses a start that must be
    // ignored.
    task automatic runJob(input int rows, input int cols, input int pct,
                          input int stallAt, input int stallLen, input int pokeCycle);
        int     total;
        int     cycle;
        int     stallCycles;
        int     issued;
        int     budget;
        bit     prevValid;
        bit     expDone;
        bit     finished;
        bit     st;
        entry_t e;

        total       = rows * cols * SEQ_LEN;
        cycle       = 0;
        stallCycles = 0;
        issued      = 0;
        budget      = 3 * total + 20;
        prevValid   = 1'b0;
        finished    = 1'b0;

        buildExpected(rows, cols);
        applyStimulus(rows, cols);
        expDone = (expQ.size() == 0);

        while (!finished) begin
            @(negedge clk);
            cycle++;
            start   = (cycle == pokeCycle);
            numRows = ROW_W'($urandom_range(0, 7));
            numCols = COL_W'($urandom_range(0, 7));
            st      = 1'b0;
            if (expQ.size() > 0) begin
                if (pct > 0) begin
                    st = ($urandom_range(0, 99) < pct) && (stallCycles < 2 * total + 5);
                end else if (stallAt >= 0) begin
                    st = (issued == stallAt) && (stallCycles < stallLen);
                end
            end else begin
                st = 1'($urandom_range(0, 1));
            end
            stall = st;
            if (st && (expQ.size() > 0)) stallCycles++;
            #1;

            checkOutput("busy", 32'(busy), 32'd1);
            checkOutput("done", 32'(done), 32'(expDone));
            checkOutput("whtDataValid", 32'(whtValid), 32'(prevValid));
            checkOutput("seqValid", 32'(seqValid), 32'((expQ.size() > 0) && !st));
            if (cycle == 1) checkOutput("dbgClear", dbgCnt, 32'd0);

            if (expQ.size() > 0) begin
                e = expQ[0];
                checkOutput("grayCode", 32'(grayCode), 32'(e.gray));
                checkOutput("seqSel", 32'(seqSel), 32'(e.sel));
                checkOutput("seqAddr", 32'(seqAddr), 32'(e.addr));
                checkOutput("lastSeq", 32'(lastSeq), 32'(e.last && !st));
            end else begin
                checkOutput("lastSeqIdle", 32'(lastSeq), 32'd0);
            end

            if (expDone) begin
                checkOutput("latency", 32'(cycle), 32'(total + stallCycles + 1));
                checkOutput("dbgAtDone", dbgCnt, DBG_EN ? 32'(total) : 32'd0);
                finished = 1'b1;
            end

            prevValid = (expQ.size() > 0) && !st;
            expDone   = 1'b0;
            if (prevValid) begin
                issued++;
                if (expQ.size() == 1) expDone = 1'b1;
                void'(expQ.pop_front());
            end

            if (!finished && (cycle >= budget)) begin
                checkOutput("jobTimeout", 32'd0, 32'd1);
                finished = 1'b1;
            end
        end

        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        #1;
        checkOutput("postBusy", 32'(busy), 32'd0);
        checkOutput("postDone", 32'(done), 32'd0);
        checkOutput("postGray", 32'(grayCode), 32'd0);
        checkOutput("postSel", 32'(seqSel), 32'd1);
        checkOutput("postAddr", 32'(seqAddr), 32'd0);
        checkOutput("postWhtValid", 32'(whtValid), 32'd0);
        checkOutput("postDbgHold", dbgCnt, DBG_EN ? 32'(total) : 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "Done"}, 32'(done), 32'd0);
        checkOutput({tag, "SeqValid"}, 32'(seqValid), 32'd0);
        checkOutput({tag, "LastSeq"}, 32'(lastSeq), 32'd0);
        checkOutput({tag, "WhtValid"}, 32'(whtValid), 32'd0);
        checkOutput({tag, "Gray"}, 32'(grayCode), 32'd0);
        checkOutput({tag, "Sel"}, 32'(seqSel), 32'd1);
        checkOutput({tag, "Addr"}, 32'(seqAddr), 32'd0);
        checkOutput({tag, "Dbg"}, dbgCnt, 32'd0);
    endtask

    initial begin
        int r;
        int c;

        rst     = 1'b1;
        start   = 1'b0;
        stall   = 1'b0;
        numRows = '0;
        numCols = '0;

        // Power-on reset values.
        repeat (2) @(negedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;

        // Basic 1x2 job, no stall.
        runJob(1, 2, 0, -1, 0, -1);

        // Gray wrap over five rows, with a start pulse while running.
        runJob(5, 1, 0, -1, 0, 3);

        // Three-cycle stall at entry 3 of a single pixel.
        runJob(1, 1, 0, 3, 3, -1);

        // Stall landing on the final entry.
        runJob(1, 2, 0, 9, 2, -1);

        // Empty job, with a start pulse during its DONE cycle.
        runJob(4, 0, 0, -1, 0, 1);

        // Reset at row 1, col 0, addr 2 of a 3x2 job.
        applyStimulus(3, 2);
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
            stall = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("preResetGray", 32'(grayCode), 32'd1);
        checkOutput("preResetSel", 32'(seqSel), 32'd1);
        checkOutput("preResetAddr", 32'(seqAddr), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetState("midReset");
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("noDoneAfterReset", 32'(done), 32'd0);
        end
        runJob(2, 2, 0, -1, 0, -1);

        // Debug-count job.
        runJob(2, 3, 0, -1, 0, -1);

        // Randomized jobs with random stall.
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 5);
            c = $urandom_range(1, 6);
            runJob(r, c, $urandom_range(0, 40), -1, 0, $urandom_range(1, 12));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
